data_mem_hs: RTL and testbench
==============================

// Module: data_mem_hs
// PURPOSE
//  Next-generation data memory for the RISC-V core. Accepts loads/stores over a valid/ready request channel.
//  Returns sign/zero-extended load data and an error code over a valid/ready response channel.
//  Storage is a word-wide array with byte-write lanes and a registered (synchronous) read.
//  Misaligned accesses either fault or are split into two word accesses. Sits between the MEM stage and storage.
// PARAMETERS
//  MEM_SIZE_KB      4   capacity in KiB; MEM_DEPTH = MEM_SIZE_KB*1024 bytes, WORDS = MEM_DEPTH/4
//  MISALIGN_SPLIT   1   1: misaligned accesses are serviced (split when crossing a word); 0: faulted
// PORTS
//  clk         in   1   clock, all logic on rising edge
//  rst         in   1   synchronous, active-high reset
//  req_valid   in   1   request present
//  req_ready   out  1   block can accept a request
//  req_we      in   1   1 = store, 0 = load
//  req_op      in   3   funct3: LB 000, LH 001, LW 010, LBU 100, LHU 101; stores SB 000, SH 001, SW 010
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data, low bytes used per op
//  rsp_valid   out  1   response present
//  rsp_ready   in   1   consumer accepts response
//  rsp_rdata   out  32  extended load data; 0 for stores and errors
//  rsp_err     out  2   00 OK, 01 MISALIGN, 10 RANGE, 11 ILLEGAL
// BEHAVIOUR
//  Reset:
//   - state=IDLE; req_ready=0 while rst=1; rsp_valid=0, rsp_rdata=0, rsp_err=0.
//   - Memory contents are not reset.
//  Handshakes:
//   - Request accepted on an edge with req_valid&req_ready. req_ready=1 only in IDLE (one outstanding access).
//   - rsp_* is held stable while rsp_valid&!rsp_ready. The response is retired on rsp_valid&rsp_ready, then -> IDLE.
//  Request checks (all at acceptance, in priority order):
//   - ILLEGAL: op in {011,110,111}; or store with op[2]=1.
//   - MISALIGN: only when MISALIGN_SPLIT=0. Applies to H-ops with addr[0]=1 and W-ops with addr[1:0]!=0.
//   - RANGE: last touched byte (addr+size-1) >= MEM_DEPTH. Must not wrap: compute in 33 bits.
//  FSM states: IDLE, LO, HI, RESP.
//   - Error request: IDLE -> RESP; no array access, no write. rsp_valid in cycle t+1 (t = accept cycle).
//   - Non-crossing access: IDLE -> LO -> RESP. LO does one array access at word addr[..:2]. rsp_valid in t+2.
//   - Word-crossing access (addr[1:0]+size > 4, split mode only): IDLE -> LO -> HI -> RESP.
//     LO accesses word w; HI accesses word w+1. rsp_valid in t+3.
//  Stores:
//   - Bytes are shifted to lane addr[1:0]; the byte-enable mask is generated per word.
//   - Bytes beyond lane 3 go to word w+1, lanes 0.. upward.
//   - Little-endian: byte k of the datum goes to address addr+k.
//  Loads:
//   - Bytes are gathered from the registered read data (LO and HI) in little-endian order.
//   - Then extended: LB/LH sign-extend, LBU/LHU zero-extend, LW as-is.
//  Ordering:
//   - Back-to-back requests are serialized.
//   - A load after a store to the same address returns the new data. Both are array accesses in separate cycles.
//  Reset mid-operation:
//   - FSM returns to IDLE and any pending response is dropped.
//   - A split store interrupted after LO keeps word w written; word w+1 is not written (no rollback).
// STRUCTURE
//  Package data_mem_pkg:
//   - op localparams (LB..LHU, SB..SW) and the rsp_err codes.
//   - FSM state encoding.
//   - Functions size_of(op) and extend(op, bytes).
//  Sub-module dmem_bank:
//   - WORDS x 32 array with 4-bit byte write enable and a 1-cycle registered read.
//   - Ports: clk, en, we[3:0], widx, wdata, rdata.
//  Top-level: FSM, checks, lane shifter/gather, response register.
// TESTING
//  1. SW 0xDEADBEEF @0x10, then LW @0x10 -> rsp_err=00, rdata=0xDEADBEEF.
//     LB @0x13 -> 0xFFFFFFDE. LBU @0x13 -> 0x000000DE.
//  2. SH 0x8001 @0x22, then LH @0x22 -> 0xFFFF8001; LHU @0x22 -> 0x00008001.
//     Word @0x20 bytes 0-1 are unchanged.
//  3. Split mode: SW 0x11223344 @0x0D, then LW @0x0D -> 0x11223344.
//     Word @0x0C = 0x223344xx and word @0x10 = 0xxxxxxx11. Response arrives 3 cycles after accept.
//  4. MISALIGN_SPLIT=0: LW @0x0D -> rsp_err=01, rdata=0, response 1 cycle after accept, memory unchanged.
//  5. LW @MEM_DEPTH-2 -> rsp_err=10. Op=011 -> rsp_err=11.
//     SW @0xFFFFFFFE -> RANGE, no wrap, no write.
//  6. Hold rsp_ready=0 for 5 cycles: rsp_* stable, req_ready=0.
//     Assert rst during HI of a split store -> rsp_valid=0 next cycle, word w written, word w+1 unchanged.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared opcodes, response codes, FSM encoding and load/store helpers for data_mem_hs.
package data_mem_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LW  = 3'b010;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_LHU = 3'b101;
    localparam logic [2:0] OP_SB  = 3'b000;
    localparam logic [2:0] OP_SH  = 3'b001;
    localparam logic [2:0] OP_SW  = 3'b010;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE    = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    // Access size in bytes from funct3 (only meaningful for legal ops).
    function automatic logic [2:0] size_of(input logic [2:0] op);
        case (op[1:0])
            2'b00:   size_of = 3'd1;
            2'b01:   size_of = 3'd2;
            default: size_of = 3'd4;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] extend(input logic [2:0] op, input logic [XLEN-1:0] bytes);
        case (op)
            OP_LB:   extend = {{24{bytes[7]}}, bytes[7:0]};
            OP_LH:   extend = {{16{bytes[15]}}, bytes[15:0]};
            OP_LBU:  extend = {24'd0, bytes[7:0]};
            OP_LHU:  extend = {16'd0, bytes[15:0]};
            default: extend = bytes;
        endcase
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Word-wide storage with per-byte write enables and a registered read port.
module dmem_bank #(
    parameter int unsigned WORDS = 1024,
    parameter int unsigned AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] widx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem_q[widx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata_q <= mem_q[widx];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_hs.sv
// Data memory with valid/ready request/response channels, request checking,
// misaligned split handling and load extension.
module data_mem_hs
    import data_mem_pkg::*;
#(
    parameter int unsigned MEM_SIZE_KB    = 4,
    parameter bit          MISALIGN_SPLIT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_err
);

    localparam int unsigned MEM_DEPTH = MEM_SIZE_KB * 1024;
    localparam int unsigned WORDS     = MEM_DEPTH / 4;
    localparam int unsigned AW        = $clog2(WORDS);

    state_e        state_q, state_d;
    logic          req_ready_q, req_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]    rsp_err_q, rsp_err_d;
    logic [2:0]    op_q, op_d;
    logic          we_q, we_d;
    logic [1:0]    off_q, off_d;
    logic [AW-1:0] widx_q, widx_d;
    logic          cross_q, cross_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   lo_word_q, lo_word_d;

    logic          accept_c;
    logic [2:0]    req_size_c;
    logic [32:0]   req_last_c;
    logic [1:0]    err_c;
    logic          cross_c;
    logic [2:0]    cur_size_c;
    logic [7:0]    be_c;
    logic [63:0]   wd_c;
    logic [63:0]   gather_c;
    logic [31:0]   load_c;

    logic          bank_en_c;
    logic [3:0]    bank_we_c;
    logic [AW-1:0] bank_widx_c;
    logic [31:0]   bank_wdata_c;
    logic [31:0]   bank_rdata;

    assign accept_c = req_valid & req_ready_q;

    // Request classification; the last-byte sum is 33 bits so addresses near 2^32 cannot wrap.
    always_comb begin
        req_size_c = size_of(req_op);
        req_last_c = {1'b0, req_addr} + 33'(req_size_c) - 33'd1;
        err_c      = ERR_OK;
        if ((req_op == 3'b011) || (req_op[2:1] == 2'b11) || (req_we && req_op[2])) begin
            err_c = ERR_ILLEGAL;
        end else if (!MISALIGN_SPLIT &&
                     (((req_op[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_op[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)))) begin
            err_c = ERR_MISALIGN;
        end else if (req_last_c >= 33'(MEM_DEPTH)) begin
            err_c = ERR_RANGE;
        end
        cross_c = (3'(req_addr[1:0]) + req_size_c) > 3'd4;
    end

    // Two-word lane view: low half belongs to word w, high half to word w+1.
    always_comb begin
        cur_size_c = size_of(op_q);
        case (cur_size_c)
            3'd1:    be_c = 8'h01;
            3'd2:    be_c = 8'h03;
            default: be_c = 8'h0F;
        endcase
        be_c     = be_c << off_q;
        wd_c     = 64'(wdata_q) << {off_q, 3'b000};
        gather_c = (state_q == ST_HI) ? {bank_rdata, lo_word_q} : {32'd0, bank_rdata};
        load_c   = extend(op_q, 32'(gather_c >> {off_q, 3'b000}));
    end

    // Loads read one cycle ahead so the registered read data lands in time for the response.
    always_comb begin
        bank_en_c    = 1'b0;
        bank_we_c    = 4'b0000;
        bank_widx_c  = widx_q;
        bank_wdata_c = 32'd0;
        case (state_q)
            ST_IDLE: begin
                if (accept_c && (err_c == ERR_OK) && !req_we) begin
                    bank_en_c   = 1'b1;
                    bank_widx_c = req_addr[AW+1:2];
                end
            end
            ST_LO: begin
                if (we_q) begin
                    bank_en_c    = 1'b1;
                    bank_we_c    = be_c[3:0];
                    bank_wdata_c = wd_c[31:0];
                end else if (cross_q) begin
                    bank_en_c   = 1'b1;
                    bank_widx_c = widx_q + AW'(1);
                end
            end
            ST_HI: begin
                if (we_q) begin
                    bank_en_c    = 1'b1;
                    bank_widx_c  = widx_q + AW'(1);
                    bank_we_c    = be_c[7:4];
                    bank_wdata_c = wd_c[63:32];
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        op_d        = op_q;
        we_d        = we_q;
        off_d       = off_q;
        widx_d      = widx_q;
        cross_d     = cross_q;
        wdata_d     = wdata_q;
        lo_word_d   = lo_word_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    op_d    = req_op;
                    we_d    = req_we;
                    off_d   = req_addr[1:0];
                    widx_d  = req_addr[AW+1:2];
                    cross_d = cross_c;
                    wdata_d = req_wdata;
                    if (err_c != ERR_OK) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = err_c;
                        rsp_rdata_d = 32'd0;
                    end else begin
                        state_d = ST_LO;
                    end
                end
            end
            ST_LO: begin
                if (cross_q) begin
                    state_d   = ST_HI;
                    lo_word_d = bank_rdata;
                end else begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = ERR_OK;
                    rsp_rdata_d = we_q ? 32'd0 : load_c;
                end
            end
            ST_HI: begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = ERR_OK;
                rsp_rdata_d = we_q ? 32'd0 : load_c;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        req_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= ERR_OK;
            op_q        <= 3'd0;
            we_q        <= 1'b0;
            off_q       <= 2'd0;
            widx_q      <= '0;
            cross_q     <= 1'b0;
            wdata_q     <= 32'd0;
            lo_word_q   <= 32'd0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            op_q        <= op_d;
            we_q        <= we_d;
            off_q       <= off_d;
            widx_q      <= widx_d;
            cross_q     <= cross_d;
            wdata_q     <= wdata_d;
            lo_word_q   <= lo_word_d;
        end
    end

    // Writes are suppressed while reset is asserted so an interrupted split store stops cleanly.
    dmem_bank #(
        .WORDS (WORDS),
        .AW    (AW)
    ) u_bank (
        .clk   (clk),
        .en    (bank_en_c & ~rst),
        .we    (bank_we_c),
        .widx  (bank_widx_c),
        .wdata (bank_wdata_c),
        .rdata (bank_rdata)
    );

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_hs.sv
// Randomized bench for data_mem_hs against a byte-array reference model, plus a no-split instance.
module tb_data_mem_hs;

    localparam int DEPTH = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [1:0]  rsp_err;
    logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready;
    logic [2:0]  b_req_op;
    logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
    logic [1:0]  b_rsp_err;

    always #5 clk = ~clk;

    data_mem_hs #(.MEM_SIZE_KB(4), .MISALIGN_SPLIT(1'b1)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    data_mem_hs #(.MEM_SIZE_KB(4), .MISALIGN_SPLIT(1'b0)) u_nosplit (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we), .req_op(b_req_op),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  err;
        int          lat;
        int          acc;
        bit          seen;
    } exp_t;

    exp_t       expq[$];
    logic [7:0] mm [DEPTH];
    int         nvec = 0;
    int         nfail = 0;
    int         cyc = 0;
    bit         hold = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer back-pressure: random unless a test is forcing a stall.
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1 rsp_ready = hold ? 1'b0 : (($urandom % 4) != 0);
        end
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic abort(input string msg);
        nfail++;
        $display("FAIL %s: wait bound expired", msg);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    endtask

    // Reference: what a single access must return, derived from byte-addressed little-endian memory.
    function automatic void model(input bit we, input logic [2:0] op, input logic [31:0] addr,
                                  input logic [31:0] wd, input bit split,
                                  output logic [31:0] rd, output logic [1:0] err, output int lat);
        int          size;
        longint      last;
        logic [31:0] v;
        size = (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
        last = longint'({32'd0, addr}) + longint'(size) - 1;
        rd   = 32'd0;
        err  = 2'd0;
        lat  = 2;
        v    = 32'd0;
        if (op == 3'd3 || op == 3'd6 || op == 3'd7 || (we && op[2])) err = 2'd3;
        else if (!split && ((size == 2 && addr[0]) || (size == 4 && addr[1:0] != 2'b00))) err = 2'd1;
        else if (last >= longint'(DEPTH)) err = 2'd2;
        if (err != 2'd0) begin
            lat = 1;
            return;
        end
        if (int'(addr[1:0]) + size > 4) lat = 3;
        for (int k = 0; k < size; k++) begin
            if (we) mm[int'(addr) + k] = wd[8*k +: 8];
            else    v[8*k +: 8] = mm[int'(addr) + k];
        end
        if (!we) begin
            case (op)
                3'd0:    rd = 32'($signed(v[7:0]));
                3'd1:    rd = 32'($signed(v[15:0]));
                3'd4:    rd = v & 32'h0000_00FF;
                3'd5:    rd = v & 32'h0000_FFFF;
                default: rd = v;
            endcase
        end
    endfunction

    task automatic issue(input bit we, input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] erd, output logic [1:0] eerr, output int elat);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        while (!req_ready) begin
            n++;
            if (n > 500) abort("req_ready_wait");
            @(negedge clk);
        end
        req_valid = 1'b1;
        req_we    = we;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        model(we, op, addr, wd, 1'b1, erd, eerr, elat);
        e.rdata = erd;
        e.err   = eerr;
        e.lat   = elat;
        e.acc   = cyc;
        e.seen  = 1'b0;
        expq.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (expq.size() != 0) begin
            n++;
            if (n > 500) abort("drain_wait");
            @(negedge clk);
        end
    endtask

    // Compare every response cycle: payload, latency from acceptance, and no new request acceptance.
    always @(negedge clk) begin : cmp
        exp_t h;
        if (!rst && rsp_valid) begin
            if (expq.size() == 0) begin
                nvec++;
                nfail++;
                $display("FAIL unexpected_rsp: got rsp_valid=1, expected no response");
            end else begin
                h = expq[0];
                check32("rsp_rdata", rsp_rdata, h.rdata);
                check32("rsp_err", 32'(rsp_err), 32'(h.err));
                check32("req_ready_busy", 32'(req_ready), 32'd0);
                if (!h.seen) begin
                    h.seen = 1'b1;
                    check32("rsp_latency", 32'(cyc - h.acc), 32'(h.lat));
                end
                expq[0] = h;
                if (rsp_ready) void'(expq.pop_front());
            end
        end
    end

    task automatic b_txn(input bit we, input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] rd, output logic [1:0] err, output int lat);
        int n = 0;
        @(negedge clk);
        while (!b_req_ready) begin
            n++;
            if (n > 100) abort("b_req_ready_wait");
            @(negedge clk);
        end
        b_req_valid = 1'b1;
        b_req_we    = we;
        b_req_op    = op;
        b_req_addr  = addr;
        b_req_wdata = wd;
        lat = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (lat == 1) b_req_valid = 1'b0;
            if (b_rsp_valid) break;
            if (lat > 50) abort("b_rsp_wait");
        end
        rd  = b_rsp_rdata;
        err = b_rsp_err;
    endtask

    initial begin
        logic [31:0] r, pre;
        logic [1:0]  e;
        int          l;
        int          n;
        int          sel;
        logic [31:0] a;

        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_op = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_op = 3'd0; b_req_addr = 32'd0; b_req_wdata = 32'd0;
        b_rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check32("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check32("rst_req_ready", 32'(req_ready), 32'd0);
        check32("rst_rsp_rdata", rsp_rdata, 32'd0);
        check32("rst_rsp_err", 32'(rsp_err), 32'd0);
        check32("rst_b_req_ready", 32'(b_req_ready), 32'd0);
        rst = 1'b0;

        // Give every word a known value so the model can predict all later loads.
        for (int w = 0; w < DEPTH / 4; w++) issue(1'b1, 3'b010, 32'(w * 4), $urandom, r, e, l);

        issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, r, e, l);
        issue(1'b0, 3'b010, 32'h10, 32'h0, r, e, l);
        check32("t1_lw", r, 32'hDEADBEEF);
        check32("t1_lw_err", 32'(e), 32'd0);
        issue(1'b0, 3'b000, 32'h13, 32'h0, r, e, l);
        check32("t1_lb", r, 32'hFFFFFFDE);
        issue(1'b0, 3'b100, 32'h13, 32'h0, r, e, l);
        check32("t1_lbu", r, 32'h000000DE);

        issue(1'b0, 3'b010, 32'h20, 32'h0, pre, e, l);
        issue(1'b1, 3'b001, 32'h22, 32'hABCD8001, r, e, l);
        issue(1'b0, 3'b001, 32'h22, 32'h0, r, e, l);
        check32("t2_lh", r, 32'hFFFF8001);
        issue(1'b0, 3'b101, 32'h22, 32'h0, r, e, l);
        check32("t2_lhu", r, 32'h00008001);
        issue(1'b0, 3'b010, 32'h20, 32'h0, r, e, l);
        check32("t2_word20", r, {16'h8001, pre[15:0]});

        issue(1'b1, 3'b010, 32'h0D, 32'h11223344, r, e, l);
        check32("t3_sw_lat", 32'(l), 32'd3);
        issue(1'b0, 3'b010, 32'h0D, 32'h0, r, e, l);
        check32("t3_lw", r, 32'h11223344);
        issue(1'b0, 3'b010, 32'h0C, 32'h0, r, e, l);
        check32("t3_word0c", {r[31:8], 8'h00}, 32'h22334400);
        issue(1'b0, 3'b010, 32'h10, 32'h0, r, e, l);
        check32("t3_word10", 32'(r[7:0]), 32'h11);

        issue(1'b0, 3'b010, 32'(DEPTH - 2), 32'h0, r, e, l);
        check32("t5_range_err", 32'(e), 32'd2);
        issue(1'b0, 3'b011, 32'h40, 32'h0, r, e, l);
        check32("t5_illegal_err", 32'(e), 32'd3);
        issue(1'b1, 3'b100, 32'h40, 32'h0, r, e, l);
        check32("t5_illegal_store", 32'(e), 32'd3);
        issue(1'b0, 3'b010, 32'h0, 32'h0, pre, e, l);
        issue(1'b1, 3'b010, 32'hFFFFFFFE, 32'h55AA55AA, r, e, l);
        check32("t5_wrap_err", 32'(e), 32'd2);
        check32("t5_wrap_lat", 32'(l), 32'd1);
        issue(1'b0, 3'b010, 32'h0, 32'h0, r, e, l);
        check32("t5_word0_kept", r, pre);
        issue(1'b1, 3'b000, 32'(DEPTH - 1), 32'h0000007F, r, e, l);
        check32("t5_last_byte_ok", 32'(e), 32'd0);

        // Stall the consumer: response must stay put and no new request may be taken.
        drain();
        hold = 1'b1;
        issue(1'b0, 3'b010, 32'h0D, 32'h0, pre, e, l);
        n = 0;
        while (!rsp_valid) begin
            n++;
            if (n > 20) abort("hold_rsp_wait");
            @(negedge clk);
        end
        for (int i = 0; i < 5; i++) begin
            check32("hold_valid", 32'(rsp_valid), 32'd1);
            check32("hold_rdata", rsp_rdata, 32'h11223344);
            @(negedge clk);
        end
        hold = 1'b0;
        drain();

        // Reset during HI of a split store: word w keeps its new bytes, word w+1 is untouched.
        n = 0;
        while (!req_ready) begin
            n++;
            if (n > 20) abort("rst_test_ready_wait");
            @(negedge clk);
        end
        req_valid = 1'b1; req_we = 1'b1; req_op = 3'b010; req_addr = 32'h2D; req_wdata = 32'hA1B2C3D4;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check32("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check32("midrst_req_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        mm[16'h2D] = 8'hD4;
        mm[16'h2E] = 8'hC3;
        mm[16'h2F] = 8'hB2;
        issue(1'b0, 3'b010, 32'h2C, 32'h0, r, e, l);
        check32("midrst_word2c", {r[31:8], 8'h00}, 32'hB2C3D400);
        issue(1'b0, 3'b010, 32'h30, 32'h0, r, e, l);

        for (int i = 0; i < 300; i++) begin
            sel = int'($urandom % 8);
            if (sel < 6)       a = $urandom % 64;
            else if (sel == 6) a = 32'(DEPTH - 8) + ($urandom % 8);
            else               a = $urandom;
            issue(1'($urandom % 2), 3'($urandom % 8), a, $urandom, r, e, l);
        end
        drain();

        b_txn(1'b1, 3'b010, 32'h0C, 32'hCAFEF00D, r, e, l);
        check32("b_sw_err", 32'(e), 32'd0);
        check32("b_sw_lat", 32'(l), 32'd2);
        b_txn(1'b1, 3'b010, 32'h0D, 32'h12345678, r, e, l);
        check32("b_sw_mis_err", 32'(e), 32'd1);
        b_txn(1'b0, 3'b010, 32'h0D, 32'h0, r, e, l);
        check32("b_lw_mis_err", 32'(e), 32'd1);
        check32("b_lw_mis_rdata", r, 32'd0);
        check32("b_lw_mis_lat", 32'(l), 32'd1);
        b_txn(1'b0, 3'b001, 32'h0F, 32'h0, r, e, l);
        check32("b_lh_mis_err", 32'(e), 32'd1);
        b_txn(1'b0, 3'b010, 32'h0C, 32'h0, r, e, l);
        check32("b_lw_kept", r, 32'hCAFEF00D);
        check32("b_lw_lat", 32'(l), 32'd2);
        b_txn(1'b0, 3'b101, 32'h0E, 32'h0, r, e, l);
        check32("b_lhu", r, 32'h0000CAFE);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
